step_sequencer: RTL and testbench

Sequences the CPU control unit's 4-bit step counter and produces the one-hot timing-step vector that the control logic consumes. Controls run/halt state, memory-wait stalls, end-of-instruction clears, and insertion of a fixed interrupt micro-sequence between instructions. Sits between the instruction decode/control logic and the timing-step consumers.

---
 rtl/step_sequencer.sv | 127 ++++++++++++
 tb/tb_step_sequencer.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/step_sequencer.sv
// Control-unit step sequencer: step counter, one-hot timing steps,
// run/halt/fault state and an interrupt micro-sequence between instructions.
// Ports: Clk, ResetN (async active-low); Start, StepClear, MemWait,
// Halt, Resume, IntEnable, IntReq in; StepCounter, TimeSteps, Running,
// IntCycle, IntAck, Halted, Fault out (all registered).
module step_sequencer #(
  parameter int STEP_W    = 4,
  parameter int MAX_STEP  = 15,
  parameter int INT_STEPS = 3
) (
  input  logic                 Clk,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic                 StepClear,
  input  logic                 MemWait,
  input  logic                 Halt,
  input  logic                 Resume,
  input  logic                 IntEnable,
  input  logic                 IntReq,
  output logic [STEP_W-1:0]    StepCounter,
  output logic [2**STEP_W-1:0] TimeSteps,
  output logic                 Running,
  output logic                 IntCycle,
  output logic                 IntAck,
  output logic                 Halted,
  output logic                 Fault
);

  localparam int NSTEPS = 2**STEP_W;
  localparam logic [STEP_W-1:0] MaxCnt = STEP_W'(MAX_STEP);
  localparam logic [STEP_W-1:0] IntLast = STEP_W'(INT_STEPS - 1);
  localparam logic [NSTEPS-1:0] OneHot0 = NSTEPS'(1);

  typedef enum logic [2:0] {
    sIdle, sRun, sIntr, sHalted, sFault
  } state_t;

  state_t state, nState;
  logic [STEP_W-1:0] nCnt;
  logic [1:0] rstSync;
  logic rstN;

  // Assert asynchronously, release on the second clock edge.
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) rstSync <= 2'b00;
    else         rstSync <= {rstSync[0], 1'b1};
  end

  assign rstN = rstSync[1];

  always_comb begin
    nState = state;
    nCnt   = StepCounter;
    unique case (state)
      sIdle: begin
        nCnt = '0;
        if (Start) nState = sRun;
      end
      sRun: begin
        if (Halt) begin
          nState = sHalted;
          nCnt   = '0;
        end else if (StepClear) begin
          nCnt = '0;
          if (IntEnable && IntReq) nState = sIntr;
        end else if (MemWait) begin
          nCnt = StepCounter;
        end else if (StepCounter == MaxCnt) begin
          nState = sFault;
        end else begin
          nCnt = StepCounter + 1'b1;
        end
      end
      sIntr: begin
        if (MemWait) begin
          nCnt = StepCounter;
        end else if (StepCounter == IntLast) begin
          nState = sRun;
          nCnt   = '0;
        end else begin
          nCnt = StepCounter + 1'b1;
        end
      end
      sHalted: begin
        nCnt = '0;
        if (Resume) nState = sRun;
      end
      sFault: begin
        nCnt = MaxCnt;
        if (Start) begin
          nState = sRun;
          nCnt   = '0;
        end
      end
      default: begin
        nState = sIdle;
        nCnt   = '0;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge rstN) begin
    if (!rstN) begin
      state       <= sIdle;
      StepCounter <= '0;
      TimeSteps   <= '0;
      Running     <= 1'b0;
      IntCycle    <= 1'b0;
      IntAck      <= 1'b0;
      Halted      <= 1'b0;
      Fault       <= 1'b0;
    end else begin
      state       <= nState;
      StepCounter <= nCnt;
      Running     <= (nState == sRun) || (nState == sIntr);
      IntCycle    <= (nState == sIntr);
      IntAck      <= (nState == sIntr) && (state != sIntr);
      Halted      <= (nState == sHalted);
      Fault       <= (nState == sFault);
      if ((nState == sRun) || (nState == sIntr))
        TimeSteps <= OneHot0 << nCnt;
      else
        TimeSteps <= '0;
    end
  end

endmodule

// File: tb/tb_step_sequencer.sv
// Directed bench for step_sequencer with an expected-value scoreboard.
// Each step drives inputs, queues the expected outputs, then checks them.
module tb_step_sequencer;

  logic        Clk = 1'b0;
  logic        ResetN = 1'b0;
  logic        Start = 1'b0;
  logic        StepClear = 1'b0;
  logic        MemWait = 1'b0;
  logic        Halt = 1'b0;
  logic        Resume = 1'b0;
  logic        IntEnable = 1'b0;
  logic        IntReq = 1'b0;
  logic [3:0]  StepCounter;
  logic [15:0] TimeSteps;
  logic        Running, IntCycle, IntAck, Halted, Fault;

  step_sequencer dut (
    .Clk(Clk), .ResetN(ResetN), .Start(Start), .StepClear(StepClear),
    .MemWait(MemWait), .Halt(Halt), .Resume(Resume),
    .IntEnable(IntEnable), .IntReq(IntReq),
    .StepCounter(StepCounter), .TimeSteps(TimeSteps),
    .Running(Running), .IntCycle(IntCycle), .IntAck(IntAck),
    .Halted(Halted), .Fault(Fault)
  );

  always #5 Clk = ~Clk;

  typedef struct packed {
    logic [3:0]  cnt;
    logic [15:0] ts;
    logic        run;
    logic        intc;
    logic        ack;
    logic        hlt;
    logic        flt;
  } obs_t;

  // input bits: Start StepClear MemWait Halt Resume IntEnable IntReq
  localparam logic [6:0] N  = 7'b0000000;
  localparam logic [6:0] ST = 7'b1000000;
  localparam logic [6:0] SC = 7'b0100000;
  localparam logic [6:0] MW = 7'b0010000;
  localparam logic [6:0] HL = 7'b0001000;
  localparam logic [6:0] RS = 7'b0000100;
  localparam logic [6:0] IE = 7'b0000010;
  localparam logic [6:0] IR = 7'b0000001;

  localparam int IDLE = 0, RUN = 1, INTR = 2, HALT = 3, FLT = 4;

  int tests = 0;
  int fails = 0;
  obs_t  expQ[$];
  string tagQ[$];

  function automatic obs_t mk(int st, int c, bit ack);
    obs_t e;
    logic [15:0] one;
    one    = 16'h0001;
    e.cnt  = 4'(c);
    e.ts   = (st == RUN || st == INTR) ? (one << c) : 16'h0000;
    e.run  = (st == RUN || st == INTR);
    e.intc = (st == INTR);
    e.ack  = ack;
    e.hlt  = (st == HALT);
    e.flt  = (st == FLT);
    return e;
  endfunction

  function automatic obs_t got();
    return {StepCounter, TimeSteps, Running, IntCycle, IntAck, Halted, Fault};
  endfunction

  task automatic check(input string tag, input obs_t e);
    obs_t g;
    g = got();
    tests++;
    assert (g === e) else begin
      fails++;
      $error("FAIL %s got=%h exp=%h", tag, g, e);
    end
  endtask

  task automatic drive(input logic [6:0] v);
    {Start, StepClear, MemWait, Halt, Resume, IntEnable, IntReq} = v;
  endtask

  task automatic step(input logic [6:0] v, input string tag, input obs_t e);
    drive(v);
    expQ.push_back(e);
    tagQ.push_back(tag);
    @(posedge Clk);
    #1;
    check(tagQ.pop_front(), expQ.pop_front());
  endtask

  initial begin
    #1;
    check("reset", mk(IDLE, 0, 0));
    @(negedge Clk);
    @(negedge Clk);
    ResetN = 1'b1;
    for (int i = 0; i < 3; i++) step(N, "idle", mk(IDLE, 0, 0));
    step(SC | IR | IE | RS, "idle_ignore", mk(IDLE, 0, 0));

    step(ST, "start", mk(RUN, 0, 0));
    for (int i = 1; i <= 5; i++) step(N, "count", mk(RUN, i, 0));
    step(SC, "clear", mk(RUN, 0, 0));
    for (int i = 1; i <= 3; i++) step(N, "to3", mk(RUN, i, 0));
    step(MW, "wait1", mk(RUN, 3, 0));
    step(MW, "wait2", mk(RUN, 3, 0));
    step(SC | MW, "clr_over_wait", mk(RUN, 0, 0));

    for (int i = 1; i <= 4; i++) step(IE | IR, "to4_int", mk(RUN, i, 0));
    step(SC | IE | IR, "int_entry", mk(INTR, 0, 1));
    step(SC | HL | IE | IR, "intr1", mk(INTR, 1, 0));
    step(MW | IE | IR, "intr_wait", mk(INTR, 1, 0));
    step(IE | IR, "intr2", mk(INTR, 2, 0));
    step(IE | IR, "intr_exit", mk(RUN, 0, 0));
    for (int i = 1; i <= 4; i++) step(IR, "to4_noint", mk(RUN, i, 0));
    step(SC | IR, "int_masked", mk(RUN, 0, 0));

    step(N, "h1", mk(RUN, 1, 0));
    step(N, "h2", mk(RUN, 2, 0));
    step(HL | SC, "halt", mk(HALT, 0, 0));
    step(ST, "halt_start_ign", mk(HALT, 0, 0));
    step(RS, "resume", mk(RUN, 0, 0));

    for (int i = 1; i <= 15; i++) step(N, "to15", mk(RUN, i, 0));
    step(N, "overflow", mk(FLT, 15, 0));
    step(RS, "fault_sticky", mk(FLT, 15, 0));
    step(ST, "fault_start", mk(RUN, 0, 0));

    step(N, "r1", mk(RUN, 1, 0));
    step(SC | IE | IR, "int2_entry", mk(INTR, 0, 1));
    step(N, "int2_1", mk(INTR, 1, 0));
    #2;
    ResetN = 1'b0;
    #1;
    check("async_reset", mk(IDLE, 0, 0));
    @(negedge Clk);
    ResetN = 1'b1;
    for (int i = 0; i < 3; i++) step(N, "post_reset", mk(IDLE, 0, 0));
    step(ST, "restart", mk(RUN, 0, 0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
